morse_keyer_decoder: RTL and testbench
======================================

// Module: morse_keyer_decoder
// PURPOSE
//  Single-key Morse element decoder. It conditions a raw push-button, times each
//  press to classify it as a dot or a dash, and detects the inter-letter gap.
//  On each gap it emits one packed letter code, so a user enters a letter with one
//  key instead of separate dot/dash buttons. Sits between the board key pin and
//  the letter lookup/LED logic.
// PARAMETERS
//  DEBOUNCE_CYC  4096     cycles a synced key level must hold before it is accepted
//  DASH_CYC      2800000  press length (cycles) at or above which element = dash
//  GAP_CYC       8400000  released length (cycles) that terminates a letter
//  MAX_SYMS      5        max elements per letter (code width)
//  LEN_W = $clog2(MAX_SYMS+1) (localparam); CNT_W sized to the largest of the three *_CYC values
// PORTS
//  CLKin       in   1         system clock, rising edge
//  RSTn        in   1         asynchronous active-low reset
//  key         in   1         raw key, 1 = pressed, asynchronous, bouncy
//  clear       in   1         synchronous abort of the letter in progress
//  code_o      out  MAX_SYMS  last letter; bit i = element i (0 dot, 1 dash), LSB first
//  len_o       out  LEN_W     number of valid elements in code_o (0..MAX_SYMS)
//  valid_o     out  1         one-cycle pulse: code_o/len_o/overflow_o just updated
//  overflow_o  out  1         last letter had more than MAX_SYMS elements
//  busy_o      out  1         letter in progress (FSM not IDLE)
// BEHAVIOUR
//  Reset: all flops cleared. code_o=0, len_o=0, valid_o=0, overflow_o=0, busy_o=0,
//   FSM=IDLE, key_db=0. Reset mid-letter discards the letter; no valid_o follows.
//  Input: 2-FF synchroniser, then debounce. key_db takes the synced value after it
//   differs from key_db for DEBOUNCE_CYC consecutive cycles. Any return to equality
//   zeroes the debounce counter. A glitch shorter than DEBOUNCE_CYC is never seen.
//  Timing counters saturate at their threshold and never wrap.
//  FSM states: IDLE, PRESS, GAP, EMIT.
//   IDLE : key_db rises -> PRESS, press_cnt=1.
//   PRESS: press_cnt++ each cycle key_db=1 (saturates at DASH_CYC).
//          key_db falls -> element = (press_cnt >= DASH_CYC), then go to GAP, gap_cnt=1.
//          If acc_len < MAX_SYMS: acc_code[acc_len]=element and acc_len++.
//          Otherwise the element is discarded and ovf_acc is set.
//   GAP  : key_db rises -> PRESS, press_cnt=1 (same letter).
//          Else gap_cnt++. When gap_cnt == GAP_CYC -> EMIT.
//   EMIT : one cycle. code_o<=acc_code, len_o<=acc_len, overflow_o<=ovf_acc, valid_o=1.
//          acc_* and ovf_acc are cleared, then -> IDLE.
//          key_db high in EMIT is serviced from IDLE on the next cycle.
//  Latency: valid_o is high exactly GAP_CYC+1 cycles after the cycle in which key_db fell.
//  code_o bits at index >= len_o are always 0. Outputs hold until the next EMIT.
//  clear=1: FSM -> IDLE and acc_*/ovf_acc/counters are zeroed next edge.
//   code_o/len_o/overflow_o keep their values.
//   clear during EMIT wins: no valid_o pulse and held outputs are not updated.
//   Key held high during clear: a new press starts only after a fresh key_db rise.
//  busy_o = (state != IDLE), registered with the state.
// TESTING (bench params: DEBOUNCE_CYC=4, DASH_CYC=20, GAP_CYC=50, MAX_SYMS=5)
//  1 Dot then dash: key high 10, low 10, high 30, low 60
//     -> one valid_o pulse; len_o=2, code_o=5'b00010, overflow_o=0.
//  2 Threshold: press of exactly 20 debounced cycles -> code_o[0]=1.
//     Press of 19 -> code_o[0]=0. Both give len_o=1.
//  3 Bounce: 3-cycle pulses separated by 2-cycle lows, no steady level
//     -> key_db stays 0, busy_o stays 0, no valid_o.
//  4 Overflow: 7 dashes then gap -> len_o=5, code_o=5'b11111, overflow_o=1.
//     The next clean 1-dot letter -> overflow_o=0, len_o=1.
//  5 Async reset asserted mid-PRESS of 2nd element -> all outputs 0 immediately.
//     After release, no valid_o until a new letter completes.
//  6 clear pulsed in GAP after 2 elements -> no valid_o, code_o/len_o keep the
//     previous letter. The next letter decodes from element 0.

Source files
------------

// File: rtl/morse_keyer_decoder.sv
// Single-key Morse element decoder: synchronises and debounces a raw key, times
// each press as dot/dash, and emits one packed letter code per inter-letter gap.
module morse_keyer_decoder #(
   parameter  int unsigned DEBOUNCE_CYC = 4096,
   parameter  int unsigned DASH_CYC     = 2800000,
   parameter  int unsigned GAP_CYC      = 8400000,
   parameter  int unsigned MAX_SYMS     = 5,
   localparam int unsigned LEN_W        = $clog2(MAX_SYMS + 1)
) (
   input  logic                CLKin,
   input  logic                RSTn,
   input  logic                key,
   input  logic                clear,
   output logic [MAX_SYMS-1:0] code_o,
   output logic [LEN_W-1:0]    len_o,
   output logic                valid_o,
   output logic                overflow_o,
   output logic                busy_o
);

   localparam int unsigned MAX_AB  = (DEBOUNCE_CYC > DASH_CYC) ? DEBOUNCE_CYC : DASH_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_CYC);
   localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_SYMS);

   typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_sync1, r_sync2, r_key_db, r_key_db_d, r_from_emit;
   logic [CNT_W-1:0]    r_db_cnt;
   logic [CNT_W-1:0]    r_press_cnt, w_press_nxt;
   logic [CNT_W-1:0]    r_gap_cnt, w_gap_nxt;
   logic [MAX_SYMS-1:0] r_acc_code, w_acc_code_nxt;
   logic [LEN_W-1:0]    r_acc_len, w_acc_len_nxt;
   logic                r_ovf_acc, w_ovf_nxt;
   logic                w_rise, w_fall, w_elem, w_emit;

   always_ff @(posedge CLKin or negedge RSTn) begin
      if (!RSTn) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_key_db   <= 1'b0;
         r_key_db_d <= 1'b0;
         r_db_cnt   <= '0;
      end else begin
         r_sync1    <= key;
         r_sync2    <= r_sync1;
         r_key_db_d <= r_key_db;
         if (r_sync2 == r_key_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DEB_LIM) begin
            r_key_db <= r_sync2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + CNT_ONE;
         end
      end
   end

   assign w_rise = r_key_db & ~r_key_db_d;
   assign w_fall = ~r_key_db & r_key_db_d;
   assign w_elem = (r_press_cnt >= DASH_LIM);

   always_comb begin
      w_state_nxt    = r_state;
      w_press_nxt    = r_press_cnt;
      w_gap_nxt      = r_gap_cnt;
      w_acc_code_nxt = r_acc_code;
      w_acc_len_nxt  = r_acc_len;
      w_ovf_nxt      = r_ovf_acc;
      w_emit         = 1'b0;
      case (r_state)
         IDLE: begin
            // a rise that landed during EMIT is no longer an edge here
            if (w_rise | (r_from_emit & r_key_db)) begin
               w_state_nxt = PRESS;
               w_press_nxt = CNT_ONE;
            end
         end
         PRESS: begin
            if (w_fall) begin
               w_state_nxt = GAP;
               w_gap_nxt   = CNT_ONE;
               if (r_acc_len < LEN_MAX) begin
                  w_acc_code_nxt = r_acc_code | (MAX_SYMS'(w_elem) << r_acc_len);
                  w_acc_len_nxt  = r_acc_len + LEN_W'(1);
               end else begin
                  w_ovf_nxt = 1'b1;
               end
            end else if (r_press_cnt < DASH_LIM) begin
               w_press_nxt = r_press_cnt + CNT_ONE;
            end
         end
         GAP: begin
            if (w_rise) begin
               w_state_nxt = PRESS;
               w_press_nxt = CNT_ONE;
            end else if (r_gap_cnt >= GAP_LIM - CNT_ONE) begin
               w_state_nxt = EMIT;
               w_gap_nxt   = GAP_LIM;
            end else begin
               w_gap_nxt = r_gap_cnt + CNT_ONE;
            end
         end
         EMIT: begin
            w_emit         = 1'b1;
            w_state_nxt    = IDLE;
            w_press_nxt    = '0;
            w_gap_nxt      = '0;
            w_acc_code_nxt = '0;
            w_acc_len_nxt  = '0;
            w_ovf_nxt      = 1'b0;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (clear) begin
         w_state_nxt    = IDLE;
         w_press_nxt    = '0;
         w_gap_nxt      = '0;
         w_acc_code_nxt = '0;
         w_acc_len_nxt  = '0;
         w_ovf_nxt      = 1'b0;
         w_emit         = 1'b0;
      end
   end

   always_ff @(posedge CLKin or negedge RSTn) begin
      if (!RSTn) begin
         r_state     <= IDLE;
         r_press_cnt <= '0;
         r_gap_cnt   <= '0;
         r_acc_code  <= '0;
         r_acc_len   <= '0;
         r_ovf_acc   <= 1'b0;
         r_from_emit <= 1'b0;
         code_o      <= '0;
         len_o       <= '0;
         overflow_o  <= 1'b0;
         valid_o     <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_press_cnt <= w_press_nxt;
         r_gap_cnt   <= w_gap_nxt;
         r_acc_code  <= w_acc_code_nxt;
         r_acc_len   <= w_acc_len_nxt;
         r_ovf_acc   <= w_ovf_nxt;
         r_from_emit <= (r_state == EMIT) & ~clear;
         valid_o     <= w_emit;
         busy_o      <= (w_state_nxt != IDLE);
         if (w_emit) begin
            code_o     <= r_acc_code;
            len_o      <= r_acc_len;
            overflow_o <= r_ovf_acc;
         end
      end
   end

endmodule

// File: tb/tb_morse_keyer_decoder.sv
// Self-checking bench for morse_keyer_decoder: directed scenarios plus random
// letters checked against a press-length based letter model.
module tb_morse_keyer_decoder;

   localparam int unsigned DEB  = 4;
   localparam int unsigned DASH = 20;
   localparam int unsigned GAP  = 50;
   localparam int unsigned MS   = 5;
   localparam int unsigned LW   = 3;
   localparam int unsigned LAT  = 2 + DEB + GAP + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          key = 1'b0;
   logic          clr = 1'b0;
   logic [MS-1:0] code;
   logic [LW-1:0] len;
   logic          valid, ovf, busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_valid = 0;
   int v_cyc   = 0;
   int t_fall  = 0;
   logic [MS-1:0] v_code = '0;
   logic [LW-1:0] v_len = '0;
   logic          v_ovf = 1'b0;
   int press_q[$];

   morse_keyer_decoder #(
      .DEBOUNCE_CYC(DEB),
      .DASH_CYC    (DASH),
      .GAP_CYC     (GAP),
      .MAX_SYMS    (MS)
   ) dut (
      .CLKin     (clk),
      .RSTn      (rst_n),
      .key       (key),
      .clear     (clr),
      .code_o    (code),
      .len_o     (len),
      .valid_o   (valid),
      .overflow_o(ovf),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (valid) begin
         n_valid++;
         v_cyc  = cyc;
         v_code = code;
         v_len  = len;
         v_ovf  = ovf;
      end
   end

   initial begin
      #900000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Letter model: one element per press, dash iff press >= DASH, truncated at MS.
   task automatic model(output logic [MS-1:0] c, output logic [LW-1:0] l, output logic o);
      int n;
      n = press_q.size();
      c = '0;
      l = LW'((n > int'(MS)) ? int'(MS) : n);
      o = (n > int'(MS));
      for (int i = 0; i < int'(l); i++) c[i] = (press_q[i] >= int'(DASH));
   endtask

   task automatic hold(input logic lvl, input int n);
      key = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_letter(input string tag, input int intra);
      int start;
      logic [MS-1:0] ec;
      logic [LW-1:0] el;
      logic          eo;
      start = n_valid;
      model(ec, el, eo);
      for (int i = 0; i < press_q.size(); i++) begin
         hold(1'b1, press_q[i]);
         key = 1'b0;
         if (i != press_q.size() - 1)
            hold(1'b0, (intra > 0) ? intra : int'($urandom_range(6, 30)));
      end
      t_fall = cyc;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (n_valid != start) break;
      end
      check({tag, "_pulse"}, 32'(n_valid - start), 32'(1));
      check({tag, "_latency"}, 32'(v_cyc - t_fall), 32'(LAT));
      check({tag, "_code"}, 32'(v_code), 32'(ec));
      check({tag, "_len"}, 32'(v_len), 32'(el));
      check({tag, "_ovf"}, 32'(v_ovf), 32'(eo));
      repeat (5) @(negedge clk);
      #1;
      check({tag, "_single"}, 32'(n_valid - start), 32'(1));
      check({tag, "_hold"}, 32'({ovf, len, code}), 32'({eo, el, ec}));
      check({tag, "_idle"}, 32'(busy), 32'(0));
   endtask

   initial begin
      int start;
      logic [MS-1:0] pc;
      logic [LW-1:0] pl;

      #12;
      check("rst_code", 32'(code), 32'(0));
      check("rst_len", 32'(len), 32'(0));
      check("rst_flags", 32'({valid, ovf, busy}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // dot then dash, fixed 10-cycle inter-element low
      press_q = '{10, 30};
      send_letter("t1", 10);
      check("t1_const", 32'({ovf, len, code}), 32'({1'b0, 3'd2, 5'b00010}));

      press_q = '{20};
      send_letter("t2_dash20", 0);
      check("t2_bit20", 32'(code[0]), 32'(1));
      press_q = '{19};
      send_letter("t2_dot19", 0);
      check("t2_bit19", 32'(code[0]), 32'(0));

      // bounce: short highs never survive the debounce window
      start = n_valid;
      for (int i = 0; i < 12; i++) begin
         key = 1'b1;
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("t3_busy", 32'(busy), 32'(0));
         end
         key = 1'b0;
         for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("t3_busy", 32'(busy), 32'(0));
         end
      end
      repeat (80) @(negedge clk);
      #1;
      check("t3_novalid", 32'(n_valid - start), 32'(0));
      check("t3_keydb", 32'(dut.r_key_db), 32'(0));

      press_q = '{25, 25, 25, 25, 25, 25, 25};
      send_letter("t4_ovf", 0);
      check("t4_const", 32'({ovf, len, code}), 32'({1'b1, 3'd5, 5'b11111}));
      press_q = '{8};
      send_letter("t4_after", 0);
      check("t4_after_const", 32'({ovf, len, code}), 32'({1'b0, 3'd1, 5'b00000}));

      // async reset mid-press of the second element
      press_q = '{30};
      send_letter("t5_pre", 0);
      hold(1'b1, 10);
      hold(1'b0, 10);
      hold(1'b1, 10);
      check("t5_busy_pre", 32'(busy), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_outs", 32'({valid, ovf, busy, len, code}), 32'(0));
      key = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      start = n_valid;
      repeat (100) @(negedge clk);
      #1;
      check("t5_novalid", 32'(n_valid - start), 32'(0));
      press_q = '{30};
      send_letter("t5_post", 0);

      // clear during the gap after two elements
      press_q = '{8, 30};
      send_letter("t6_pre", 0);
      pc = code;
      pl = len;
      start = n_valid;
      hold(1'b1, 25);
      hold(1'b0, 10);
      hold(1'b1, 10);
      hold(1'b0, 20);
      check("t6_busy_gap", 32'(busy), 32'(1));
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("t6_busy_clr", 32'(busy), 32'(0));
      repeat (100) @(negedge clk);
      #1;
      check("t6_novalid", 32'(n_valid - start), 32'(0));
      check("t6_keep", 32'({len, code}), 32'({pl, pc}));
      press_q = '{25};
      send_letter("t6_post", 0);

      for (int k = 0; k < 15; k++) begin
         int n;
         n = int'($urandom_range(1, 7));
         press_q.delete();
         for (int i = 0; i < n; i++) press_q.push_back(int'($urandom_range(5, 40)));
         send_letter("rnd", 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
